// File: rtl/scytale_encryption.sv
// rtl/scytale_encryption.sv - scytale transposition cipher: collects a message, then streams its columns row by row
module scytale_encryption #(
    parameter int D_WIDTH = 8,
    parameter int KEY_WIDTH = 8,
    parameter int MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);
    localparam int LW = 2 * KEY_WIDTH;
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int AW = $clog2(MAX_NOF_CHARS);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_NOF_CHARS);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_NOF_CHARS);

    typedef enum logic {IDLE, ENCRYPT} state_t;

    state_t state, next_state;

    logic [D_WIDTH-1:0]   buf_mem [MAX_NOF_CHARS];
    logic [CW-1:0]        count;
    logic [KEY_WIDTH-1:0] n_r, m_r;
    logic [LW-1:0]        len_r, out_cnt, idx;
    logic [KEY_WIDTH-1:0] row_i, col_j;
    logic [D_WIDTH-1:0]   rd_data;
    logic                 bad_key, is_token, emit, finish;

    assign is_token = valid_i && (data_i == START_ENCRYPTION_TOKEN);
    assign bad_key  = (n_r == '0) || (m_r == '0) || (len_r > MAX_L);
    assign rd_data  = (idx < MAX_L) ? buf_mem[AW'(idx)] : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (is_token) next_state = ENCRYPT;
            ENCRYPT: begin
                // A bad key set leaves after a single busy cycle without emitting anything
                if (bad_key || out_cnt == len_r) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else begin
                    emit = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || finish) begin
            for (int a = 0; a < MAX_NOF_CHARS; a++) buf_mem[a] <= '0;
            count   <= '0;
            n_r     <= '0;
            m_r     <= '0;
            len_r   <= '0;
            out_cnt <= '0;
            idx     <= '0;
            row_i   <= '0;
            col_j   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            busy    <= 1'b0;
        end else if (state == IDLE) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            busy    <= is_token;
            if (is_token) begin
                n_r   <= key_N;
                m_r   <= key_M;
                len_r <= LW'(key_N) * LW'(key_M);
            end else if (valid_i && count < MAX_C) begin
                buf_mem[AW'(count)] <= data_i;
                count <= count + CW'(1);
            end
        end else if (emit) begin
            data_o  <= rd_data;
            valid_o <= 1'b1;
            out_cnt <= out_cnt + LW'(1);
            // Walk down a column by stepping M; after N steps move to the next column
            if (row_i == n_r - KEY_WIDTH'(1)) begin
                row_i <= '0;
                col_j <= col_j + KEY_WIDTH'(1);
                idx   <= LW'(col_j + KEY_WIDTH'(1));
            end else begin
                row_i <= row_i + KEY_WIDTH'(1);
                idx   <= idx + LW'(m_r);
            end
        end
    end
endmodule

// File: tb/tb_scytale_encryption.sv
// tb/tb_scytale_encryption.sv - table-driven bench for scytale_encryption
module tb_scytale_encryption;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N, key_M;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;

    int passed = 0;
    int total  = 0;

    scytale_encryption dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .key_N(key_N), .key_M(key_M), .data_o(data_o), .valid_o(valid_o), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    n;
        int    m;
        string msg;
        string exp;     // '_' stands for a zero character
        int    busy_c;
    } vec_t;

    vec_t tab [8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_q(input string name, input byte act[$], input byte exp[$]);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %p expected %p", name, act, exp);
    endtask

    task automatic send_msg(input byte msg[$], input int n, input int m);
        key_N = 8'(n);
        key_M = 8'(m);
        foreach (msg[i]) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = msg[i];
        end
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 8'hFA;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic run_msg(input byte msg[$], input int n, input int m, input bit noise,
                           output byte got[$], output int bc, output int bad0);
        got  = {};
        bc   = 0;
        bad0 = 0;
        send_msg(msg, n, m);
        for (int c = 0; c < 400; c++) begin
            if (!busy && !valid_o) break;
            if (busy) bc++;
            if (valid_o) got.push_back(byte'(data_o));
            else if (data_o != 8'h00) bad0++;
            if (noise) begin
                valid_i = 1'b1;
                data_i  = (c % 2 == 1) ? 8'hFA : 8'h51;
                key_N   = 8'(c + 3);
                key_M   = 8'd1;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        byte msg[$], exp[$], got[$];
        int  bc, bad0;
        msg = {};
        exp = {};
        for (int i = 0; i < v.msg.len(); i++) msg.push_back(v.msg[i]);
        for (int i = 0; i < v.exp.len(); i++) exp.push_back(v.exp[i] == "_" ? 8'h00 : v.exp[i]);
        run_msg(msg, v.n, v.m, 1'b0, got, bc, bad0);
        check_q({tag, " data"}, got, exp);
        check({tag, " busy_cycles"}, bc, v.busy_c);
        check({tag, " valid_cycles"}, got.size(), exp.size());
        check({tag, " idle_data_zero"}, bad0, 0);
    endtask

    initial begin
        byte msg[$], exp[$], got[$];
        int  bc, bad0, vc, quiet;

        tab[0] = '{n: 2, m: 3, msg: "ABCDEF", exp: "ADBECF", busy_c: 7};
        tab[1] = '{n: 3, m: 2, msg: "ABCDEF", exp: "ACEBDF", busy_c: 7};
        tab[2] = '{n: 2, m: 2, msg: "AB",     exp: "A_B_",   busy_c: 5};
        tab[3] = '{n: 0, m: 5, msg: "",       exp: "",       busy_c: 1};
        tab[4] = '{n: 2, m: 2, msg: "WXYZ",   exp: "WYXZ",   busy_c: 5};
        tab[5] = '{n: 1, m: 1, msg: "",       exp: "_",      busy_c: 2};
        tab[6] = '{n: 8, m: 7, msg: "AB",     exp: "",       busy_c: 1};
        tab[7] = '{n: 2, m: 1, msg: "Q",      exp: "Q_",     busy_c: 3};

        rst = 1'b1; valid_i = 1'b1; data_i = 8'h41; key_N = 8'd2; key_M = 8'd2;
        repeat (3) @(negedge clk);
        check("reset data_o", data_o, 0);
        check("reset valid_o", valid_o, 0);
        check("reset busy", busy, 0);
        valid_i = 1'b0; data_i = 8'h00;
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 8; t++) run_vec(tab[t], $sformatf("vec%0d", t));

        // 52 characters into a 50-deep buffer, with input noise while busy
        msg = {};
        exp = {};
        for (int c = 0; c < 52; c++) msg.push_back(byte'(8'h20 + c));
        for (int k = 0; k < 50; k++) exp.push_back(msg[(k % 5) * 10 + k / 5]);
        run_msg(msg, 5, 10, 1'b1, got, bc, bad0);
        check_q("overflow data", got, exp);
        check("overflow busy_cycles", bc, 51);
        check("overflow valid_cycles", got.size(), 50);
        check("overflow idle_data_zero", bad0, 0);
        run_vec(tab[4], "after_noise");

        // reset in the middle of an encryption
        msg = {};
        for (int i = 0; i < 6; i++) msg.push_back(byte'(8'h41 + i));
        send_msg(msg, 2, 3);
        vc = 0;
        for (int c = 0; c < 50; c++) begin
            if (valid_o) vc++;
            if (vc == 3) break;
            @(negedge clk);
        end
        check("midreset outputs_before", vc, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midreset data_o", data_o, 0);
        check("midreset valid_o", valid_o, 0);
        check("midreset busy", busy, 0);
        rst = 1'b0;
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_o || busy) quiet++;
        end
        check("midreset quiet", quiet, 0);
        run_vec(tab[0], "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
